// File: rtl/bus_cycle_decoder.sv
// Purpose : decode each 65C816 bus cycle into a chip-select code and stretch slow-device cycles via RDY.
// Latency : outputs update 1 clk after phi2 rises (clk edge that detects the rise); release 1 clk after the detected fall.
// Backpressure: none accepted; the block applies backpressure to the CPU by holding rdy low for the device's wait count.
//
// Ports:
//   clk            system clock, only clock; phi2 is a synchronous input in this domain
//   reset_n        asynchronous active-low reset
//   phi2           CPU PHI2
//   addr[23:0]     CPU address {bank, A15..A0}
//   vda, vpa       CPU valid data / program address
//   device_select  registered device code, 0 = none
//   rdy            CPU RDY, low stretches the current cycle
//   cycle_active   high while a decoded cycle is in progress
module bus_cycle_decoder #(
    parameter logic [7:0] IO_BANK      = 8'h00,
    parameter logic [7:0] IO_PAGE      = 8'hDF,
    parameter logic [7:0] VRAM_BANK_LO = 8'h10,
    parameter logic [7:0] VRAM_BANK_HI = 8'h1F,
    parameter logic [2:0] WAIT_EXP     = 3'd4,
    parameter logic [2:0] WAIT_AUDIO   = 3'd2,
    parameter logic [2:0] WAIT_VIA     = 3'd2,
    parameter logic [2:0] WAIT_SMC     = 3'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi2,
    input  logic [23:0] addr,
    input  logic        vda,
    input  logic        vpa,
    output logic [3:0]  device_select,
    output logic        rdy,
    output logic        cycle_active
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       phi2_q;

    logic       phi2_rise;
    logic       phi2_fall;
    logic [7:0] bank;
    logic [3:0] code_dec;
    logic [2:0] wait_dec;

    assign phi2_rise = phi2 & ~phi2_q;
    assign phi2_fall = ~phi2 & phi2_q;
    assign bank      = addr[23:16];

    // Address decode, highest priority first: no valid address, I/O page, VRAM banks, RAM.
    always_comb begin
        code_dec = 4'd0;
        if (!(vda | vpa)) begin
            code_dec = 4'd0;
        end else if (bank == IO_BANK && addr[15:8] == IO_PAGE) begin
            case (addr[7:4])
                4'h0, 4'h1: code_dec = 4'd1;   // EXP
                4'h2:       code_dec = 4'd2;   // AUDIO
                4'h3:       code_dec = 4'd3;   // VIDEO
                4'h4:       code_dec = 4'd4;   // IRQ
                4'h5:       code_dec = 4'd5;   // SPI
                4'h6:       code_dec = 4'd6;   // VIA
                4'h7:       code_dec = 4'd7;   // SMC
                4'h8:       code_dec = 4'd10;  // MMU
                default:    code_dec = 4'd1;   // upper I/O slots map to EXP
            endcase
        end else if (bank >= VRAM_BANK_LO && bank <= VRAM_BANK_HI) begin
            code_dec = 4'd9;                   // VRAM
        end else begin
            code_dec = 4'd8;                   // RAM
        end
    end

    // Extra PHI2 cycles per device; only the slow peripherals stretch.
    always_comb begin
        wait_dec = 3'd0;
        case (code_dec)
            4'd1:    wait_dec = WAIT_EXP;
            4'd2:    wait_dec = WAIT_AUDIO;
            4'd6:    wait_dec = WAIT_VIA;
            4'd7:    wait_dec = WAIT_SMC;
            default: wait_dec = 3'd0;
        endcase
    end

    // Address and status are only looked at on a rise in IDLE, so the code
    // latched there holds for the whole cycle regardless of bus activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= 3'd0;
            phi2_q        <= 1'b0;
            device_select <= 4'd0;
            rdy           <= 1'b1;
            cycle_active  <= 1'b0;
        end else begin
            phi2_q <= phi2;
            case (state)
                ST_IDLE: begin
                    if (phi2_rise && code_dec != 4'd0) begin
                        device_select <= code_dec;
                        cycle_active  <= 1'b1;
                        if (wait_dec == 3'd0) begin
                            state <= ST_ACTIVE;
                        end else begin
                            rdy   <= 1'b0;
                            cnt   <= wait_dec;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (phi2_fall) begin
                        cnt <= cnt - 3'd1;
                        // Releasing on the last counted fall leaves one more
                        // high phase for the CPU to complete the access.
                        if (cnt <= 3'd1) begin
                            rdy   <= 1'b1;
                            state <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (phi2_fall) begin
                        device_select <= 4'd0;
                        cycle_active  <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cnt           <= 3'd0;
                    device_select <= 4'd0;
                    rdy           <= 1'b1;
                    cycle_active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Directed bench for bus_cycle_decoder: PHI2 is driven as 4 clk high / 4 clk low,
// inputs change and outputs are sampled on the falling clk edge.
module tb_bus_cycle_decoder;

    logic        clk;
    logic        reset_n;
    logic        phi2;
    logic [23:0] addr;
    logic        vda;
    logic        vpa;
    logic [3:0]  device_select;
    logic        rdy;
    logic        cycle_active;

    int checks;
    int errors;

    bus_cycle_decoder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .phi2          (phi2),
        .addr          (addr),
        .vda           (vda),
        .vpa           (vpa),
        .device_select (device_select),
        .rdy           (rdy),
        .cycle_active  (cycle_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Drive phi2 and advance n falling clk edges.
    task automatic phase(input logic v, input int n);
        phi2 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        phi2 = 1'b0; addr = 24'h0; vda = 1'b0; vpa = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (device_select !== 4'd0) begin errors++; $display("FAIL reset_sel actual=%0d required=0", device_select); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy actual=%b required=1", rdy); end
        checks++; if (cycle_active !== 1'b0) begin errors++; $display("FAIL reset_active actual=%b required=0", cycle_active); end
        reset_n = 1'b1;
        phase(1'b0, 4);
    endtask

    // One full bus cycle: decode on the rise, wt stretched falls, then the terminating fall.
    task automatic test_cycle(input string name, input logic [23:0] a, input logic d, input logic p,
                              input logic [3:0] code, input int wt, input logic change_addr);
        addr = a; vda = d; vpa = p;
        phase(1'b1, 1);
        checks++; if (device_select !== code) begin errors++; $display("FAIL %s decode_sel actual=%0d required=%0d", name, device_select, code); end
        checks++; if (cycle_active !== 1'b1) begin errors++; $display("FAIL %s decode_active actual=%b required=1", name, cycle_active); end
        checks++; if (rdy !== (wt == 0)) begin errors++; $display("FAIL %s decode_rdy actual=%b required=%b", name, rdy, (wt == 0)); end
        if (change_addr) addr = 24'h00DF20;
        phase(1'b1, 3);
        for (int k = 1; k <= wt; k++) begin
            phase(1'b0, 1);
            checks++; if (rdy !== (k == wt)) begin errors++; $display("FAIL %s fall%0d_rdy actual=%b required=%b", name, k, rdy, (k == wt)); end
            checks++; if (device_select !== code) begin errors++; $display("FAIL %s fall%0d_sel actual=%0d required=%0d", name, k, device_select, code); end
            phase(1'b0, 3);
            phase(1'b1, 2);
            checks++; if (device_select !== code) begin errors++; $display("FAIL %s high%0d_sel actual=%0d required=%0d", name, k, device_select, code); end
            phase(1'b1, 2);
        end
        phase(1'b0, 1);
        checks++; if (device_select !== 4'd0) begin errors++; $display("FAIL %s end_sel actual=%0d required=0", name, device_select); end
        checks++; if (cycle_active !== 1'b0) begin errors++; $display("FAIL %s end_active actual=%b required=0", name, cycle_active); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s end_rdy actual=%b required=1", name, rdy); end
        phase(1'b0, 3);
        vda = 1'b0; vpa = 1'b0;
    endtask

    task automatic test_no_access();
        addr = 24'h00DF60; vda = 1'b0; vpa = 1'b0;
        phase(1'b1, 1);
        checks++; if (device_select !== 4'd0) begin errors++; $display("FAIL noacc_sel actual=%0d required=0", device_select); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL noacc_rdy actual=%b required=1", rdy); end
        checks++; if (cycle_active !== 1'b0) begin errors++; $display("FAIL noacc_active actual=%b required=0", cycle_active); end
        phase(1'b1, 3);
        phase(1'b0, 1);
        checks++; if (device_select !== 4'd0 || cycle_active !== 1'b0) begin errors++; $display("FAIL noacc_fall actual=%0d/%b required=0/0", device_select, cycle_active); end
        phase(1'b0, 3);
    endtask

    task automatic test_reset_mid_wait();
        addr = 24'h00DF65; vda = 1'b1; vpa = 1'b0;
        phase(1'b1, 4);
        phase(1'b0, 4);   // first fall: VIA count now 1, rdy still low
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midwait_rdy_before actual=%b required=0", rdy); end
        #2;
        reset_n = 1'b0;
        #1;               // still before the next rising clk edge
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL async_reset_rdy actual=%b required=1", rdy); end
        checks++; if (device_select !== 4'd0) begin errors++; $display("FAIL async_reset_sel actual=%0d required=0", device_select); end
        checks++; if (cycle_active !== 1'b0) begin errors++; $display("FAIL async_reset_active actual=%b required=0", cycle_active); end
        vda = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        phase(1'b0, 2);
        test_cycle("smc_after_reset", 24'h00DF70, 1'b1, 1'b0, 4'd7, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_cycle("b2b_audio", 24'h00DF2C, 1'b1, 1'b0, 4'd2, 2, 1'b0);
        test_cycle("b2b_video", 24'h00DF30, 1'b0, 1'b1, 4'd3, 0, 1'b0);
        test_cycle("b2b_vram_hi", 24'h1F0000, 1'b1, 1'b0, 4'd9, 0, 1'b0);
        test_cycle("b2b_ram_20", 24'h20DF10, 1'b1, 1'b0, 4'd8, 0, 1'b0);
        test_cycle("b2b_exp_low", 24'h00DF15, 1'b1, 1'b0, 4'd1, 4, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cycle("via", 24'h00DF65, 1'b1, 1'b0, 4'd6, 2, 1'b0);
        test_cycle("vram", 24'h123456, 1'b0, 1'b1, 4'd9, 0, 1'b0);
        test_cycle("ram", 24'h004000, 1'b1, 1'b0, 4'd8, 0, 1'b0);
        test_cycle("mmu", 24'h00DF85, 1'b1, 1'b0, 4'd10, 0, 1'b0);
        test_cycle("exp_high", 24'h00DFA0, 1'b1, 1'b0, 4'd1, 4, 1'b0);
        test_no_access();
        test_cycle("via_addr_hold", 24'h00DF65, 1'b1, 1'b0, 4'd6, 2, 1'b1);
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cycle_decoder.md
# bus_cycle_decoder

Decodes each 65C816 bus cycle into the 4-bit `device_select` code consumed by the device chip-select demux, and stretches slow-device cycles by holding CPU RDY low for a per-device number of PHI2 cycles. Sits between the CPU address/status pins (bank already demultiplexed) and the chip-select demux. Runs on the system clock, with PHI2 treated as a synchronous input generated in the same clock domain.

## Interface
- `IO_BANK`, 8'h00, bank containing the I/O page
- `IO_PAGE`, 8'hDF, address bits [15:8] of the I/O page
- `VRAM_BANK_LO`, 8'h10, first bank decoded as VRAM
- `VRAM_BANK_HI`, 8'h1F, last bank decoded as VRAM
- `WAIT_EXP`, 3'd4, extra PHI2 cycles inserted for EXP (code 1)
- `WAIT_AUDIO`, 3'd2, extra PHI2 cycles inserted for AUDIO (code 2)
- `WAIT_VIA`, 3'd2, extra PHI2 cycles inserted for VIA (code 6)
- `WAIT_SMC`, 3'd1, extra PHI2 cycles inserted for SMC (code 7); all other codes use 0
- `clk` in 1 system clock; the only clock
- `reset_n` in 1 asynchronous, active-low reset
- `phi2` in 1 CPU PHI2, synchronous to `clk`
- `addr` in 24 CPU address, {bank, A15..A0}
- `vda` in 1 CPU valid data address
- `vpa` in 1 CPU valid program address
- `device_select` out 4 registered device code; 0 = none
- `rdy` out 1 CPU RDY; low stretches the current cycle
- `cycle_active` out 1 high while a decoded cycle is in progress

## Operation
- `phi2_q` is `phi2` registered each clk. A rise is `phi2 & !phi2_q`; a fall is `!phi2 & phi2_q`.
- Decode is evaluated at a rise, in this priority order:
  - `vda|vpa`=0: code 0.
  - Bank==`IO_BANK` and addr[15:8]==`IO_PAGE`: select on addr[7:4].
    - 0x0–0x1 → 1 (EXP)
    - 0x2 → 2 (AUDIO)
    - 0x3 → 3 (VIDEO)
    - 0x4 → 4 (IRQ)
    - 0x5 → 5 (SPI)
    - 0x6 → 6 (VIA)
    - 0x7 → 7 (SMC)
    - 0x8 → 10 (MMU)
    - 0x9–0xF → 1 (EXP)
  - Bank in [`VRAM_BANK_LO`, `VRAM_BANK_HI`] inclusive → 9 (VRAM).
  - Otherwise → 8 (RAM).
- The wait count is selected by the decoded code. Codes 0, 3, 4, 5, 8, 9 and 10 use 0.
- State machine states are IDLE, WAIT and ACTIVE.
  - IDLE, rise with code 0: stay in IDLE; outputs unchanged.
  - IDLE, rise with code≠0 and wait=0: `device_select`←code, `cycle_active`←1, go to ACTIVE.
  - IDLE, rise with code≠0 and wait>0: `device_select`←code, `cycle_active`←1, `rdy`←0, `cnt`←wait, go to WAIT.
  - WAIT, on each fall: `cnt`←`cnt`−1. When the new value is 0: `rdy`←1, go to ACTIVE.
  - ACTIVE, on fall: `device_select`←0, `cycle_active`←0, go to IDLE.
- Rises outside IDLE are ignored. `addr`, `vda` and `vpa` are not re-sampled while a cycle is held.
- `device_select` is stable from the decode edge until the terminating fall edge. It never changes from one nonzero code to another without passing through 0 for at least one clk.
- `cnt` is 3 bits. Wait values are 0–7; there is no wrap.

## Timing
- Reset values: `device_select`=0, `rdy`=1, `cycle_active`=0, state IDLE, `cnt`=0, `phi2_q`=0.
- Reset asserted mid-cycle forces all of the above immediately, without waiting for a clk edge. On release, the first rise is decoded normally.
- Decode latency: outputs update on the clk edge at which the rise is detected, i.e. 1 clk after `phi2` goes high.
- `rdy` falls on that same edge, so it is low well before the next PHI2 fall. The CPU samples it at that fall.
- A wait of N holds `rdy` low across N PHI2 falls. `device_select` is held for N+1 PHI2 high phases in total.
- Release: `rdy` rises on the clk edge detecting the N-th fall. `device_select` returns to 0 on the clk edge detecting the next fall.
- Reset and a fall in the same cycle: reset wins.

## Test plan
- After reset: drive rise with addr=24'h00DF65, vda=1 → `device_select`=6 one clk after the rise, `rdy` low for exactly 2 PHI2 falls, select returns to 0 after the 3rd fall.
- addr=24'h123456, vpa=1 → `device_select`=9, `rdy` stays 1, select clears on the first fall.
- addr=24'h004000, vda=1 → code 8; addr=24'h00DF85 → code 10; addr=24'h00DFA0 → code 1 with `rdy` low for 4 falls.
- vda=vpa=0 with addr=24'h00DF60 → `device_select` stays 0, `rdy` stays 1, `cycle_active` stays 0.
- Change addr to 24'h00DF20 during a VIA wait → `device_select` remains 6 until the cycle ends.
- Assert `reset_n`=0 while in WAIT with `cnt`=1 → `rdy`=1 and `device_select`=0 without any clk edge; after release, a SMC cycle (24'h00DF70) gives exactly 1 wait.
